fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Frame-level controller for the 32-point butterfly FFT datapath. Accepts complex time samples one per handshake and assembles a 32-sample frame. Drives the frame to the butterfly core, pulses the core's reset and waits a fixed latency. It then captures the 2048-bit result and streams it out one bin per handshake. Sits between the sample source or ADC interface and the parallel butterfly core, replacing the bench-style whole-vector load and dump.

## Interface
Parameters:
- NPOINT, 32: samples per frame; index width 5.
- SAMPLE_W, 64: complex sample width; [63:32] real, [31:0] imag.
- FFT_LATENCY, 8: core cycles from fft_reset deassertion to valid fft_out; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  SAMPLE_W  time sample.
- fft_reset  out  1  reset to butterfly core.
- fft_in  out  NPOINT*SAMPLE_W  frame to core; sample k at [64k+63:64k].
- fft_out  in  NPOINT*SAMPLE_W  core result, same packing.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_data  out  SAMPLE_W  frequency bin.
- out_last  out  1  high with bin 31 of a frame.
- busy  out  1  high in START or WAIT.
- frame_count  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- Storage:
  - ibuf: 32×64 input buffer with fill counter ld_cnt (0..32); full = (ld_cnt==32).
  - obuf: 32×64 output buffer with drain index dr_idx.
  - fft_in is driven directly from ibuf registers.
- States:
  - LOAD: in_ready=!full. Each in_valid&in_ready writes ibuf[ld_cnt] and increments ld_cnt. When full, go to START next cycle.
  - START: one cycle. fft_reset=1, in_ready=0. Clear the wait counter. Go to WAIT.
  - WAIT: fft_reset=0, in_ready=0. Count 0..FFT_LATENCY-1. On the edge where count==FFT_LATENCY-1:
    - obuf←fft_out, ld_cnt←0, dr_idx←0.
    - Go to DRAIN.
  - DRAIN:
    - out_valid=1, out_data=obuf[sel(dr_idx)], out_last=(dr_idx==31).
    - in_ready=!full; the next frame loads into ibuf concurrently.
    - Each out_valid&out_ready increments dr_idx.
    - On the handshake with out_last: frame_count increments, then go to START if full (including a sample completing ibuf in that same cycle), else go to LOAD.
- ibuf is not writable in START or WAIT, so fft_in is stable for the whole core computation.
- in_data is not inspected; all 64 bits are stored as-is. No arithmetic beyond counters.
- Input handshake: samples with in_valid=1 while in_ready=0 are held by the source; none are dropped.
- Output handshake: out_data and out_last stay stable while out_valid&!out_ready.

## Timing
- Reset values, and values held while reset is high:
  - State is LOAD; ld_cnt, dr_idx, counters and frame_count are 0.
  - ibuf, obuf and fft_in are 0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - fft_reset=1, following reset.
- Reset mid-frame (any state) aborts the frame. No partial output is emitted.
- First in_ready=1 is in the cycle after reset deasserts.
- Latency from the 32nd input handshake (edge E):
  - START during cycle E+1.
  - WAIT for cycles E+2..E+1+FFT_LATENCY.
  - first out_valid in cycle E+2+FFT_LATENCY.
- Steady throughput with out_ready=1 and in_valid=1: one frame per 32+1+FFT_LATENCY cycles. The next frame's load fully overlaps the drain.
- All outputs are registered or decoded from registered state. No combinational path from in_valid or out_ready to any output.

## Configuration
- FFT_SEQ_BITREV_EN defined: sel(i)=bit-reverse of the 5-bit i, so bins are emitted in bit-reversed index order. Use this when the core produces natural order and the consumer expects decimation order, or the reverse.
- FFT_SEQ_BITREV_EN undefined: sel(i)=i, natural order.
- Handshakes and timing are identical in both builds.

## Test plan
- Reset, then 32 samples {k,0} (k=0..31) back-to-back, FFT_LATENCY=8, out_ready=1:
  - fft_reset pulses exactly one cycle, 1 cycle after the 32nd accept.
  - first out_valid 10 cycles after the 32nd accept.
  - 32 bins match fft_out; out_last only on the 32nd; frame_count=1.
- out_ready toggled 1/0 each cycle during drain: each bin is emitted exactly once, held stable while stalled, and drain takes 63 cycles.
- Second frame streamed during drain of the first, with its 32nd sample accepted in the same cycle as out_last's handshake: next state is START, no idle cycle, frame_count=1 then 2.
- in_valid=1 held through START/WAIT: in_ready=0 there, and fft_in is unchanged for all FFT_LATENCY+1 cycles.
- Reset asserted after 17 samples, then 32 new samples: no out_valid until the new frame completes, and output reflects only the new samples.
- Build with FFT_SEQ_BITREV_EN, fft_out bin k = {k,k}: output sequence is 0,16,8,24,4,…,31.

Source files
------------

// File: rtl/fft_frame_sequencer_if.sv
// Sample-in / bin-out handshake bundle for fft_frame_sequencer.
// The sequencer takes the slave view; the sample source and bin consumer take the master view.
interface fft_frame_sequencer_if #(
  parameter int SAMPLE_W = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the 32-point butterfly core: load frame, pulse core reset, wait, drain bins.
// Optional build macro FFT_SEQ_BITREV_EN: bins are drained in bit-reversed index order.
module fft_frame_sequencer #(
  parameter int NPOINT      = 32,
  parameter int SAMPLE_W    = 64,
  parameter int FFT_LATENCY = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  fft_frame_sequencer_if.slave       io,
  output logic                       fft_reset,
  output logic [NPOINT*SAMPLE_W-1:0] fft_in,
  input  logic [NPOINT*SAMPLE_W-1:0] fft_out,
  output logic                       busy,
  output logic [15:0]                frame_count
);

  localparam int IDX_W = $clog2(NPOINT);
  localparam logic [IDX_W:0] LD_FULL  = (IDX_W+1)'(NPOINT);
  localparam logic [IDX_W:0] LD_LAST  = (IDX_W+1)'(NPOINT - 1);
  localparam logic [7:0]     LAT_LAST = 8'(FFT_LATENCY - 1);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]          state;
  logic [SAMPLE_W-1:0] ibuf [NPOINT];
  logic [SAMPLE_W-1:0] obuf [NPOINT];
  logic [IDX_W:0]      ld_cnt;
  logic [IDX_W-1:0]    dr_idx;
  logic [7:0]          wait_cnt;
  logic                rst_q;

  logic full, full_next, in_fire, out_fire, last_fire;

  function automatic logic [IDX_W-1:0] sel(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] r;
`ifdef FFT_SEQ_BITREV_EN
    for (int b = 0; b < IDX_W; b++) r[b] = i[IDX_W-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  // Handshake outputs depend only on registered state, never on in_valid/out_ready.
  assign full          = (ld_cnt == LD_FULL);
  assign io.in_ready   = !rst_q && !full && ((state == LOAD) || (state == DRAIN));
  assign io.out_valid  = (state == DRAIN);
  assign io.out_last   = (state == DRAIN) && (dr_idx == {IDX_W{1'b1}});
  assign io.out_data   = (state == DRAIN) ? obuf[sel(dr_idx)] : '0;
  assign fft_reset     = rst_q || (state == START);
  assign busy          = (state == START) || (state == WAIT);

  assign in_fire   = io.in_valid && io.in_ready;
  assign out_fire  = io.out_valid && io.out_ready;
  assign last_fire = out_fire && io.out_last;
  assign full_next = full || (in_fire && (ld_cnt == LD_LAST));

  for (genvar k = 0; k < NPOINT; k++) begin : g_pack
    assign fft_in[k*SAMPLE_W +: SAMPLE_W] = ibuf[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      ld_cnt      <= '0;
      dr_idx      <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
      rst_q       <= 1'b1;
      for (int k = 0; k < NPOINT; k++) begin
        ibuf[k] <= '0;
        obuf[k] <= '0;
      end
    end else begin
      rst_q <= 1'b0;
      if (in_fire) begin
        ibuf[ld_cnt[IDX_W-1:0]] <= io.in_data;
        ld_cnt <= ld_cnt + 1'b1;
      end
      if (out_fire) dr_idx <= dr_idx + 1'b1;

      case (state)
        LOAD: if (full_next) state <= START;
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // ibuf is frozen here, so fft_out is captured from a stable frame.
          if (wait_cnt == LAT_LAST) begin
            for (int k = 0; k < NPOINT; k++) obuf[k] <= fft_out[k*SAMPLE_W +: SAMPLE_W];
            ld_cnt <= '0;
            dr_idx <= '0;
            state  <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: if (last_fire) begin
          frame_count <= frame_count + 16'd1;
          state       <= full_next ? START : LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer; the core is modelled as reverse-order + real/imag swap.
// Honours FFT_SEQ_BITREV_EN for the expected drain order.
module tb_fft_frame_sequencer;

  localparam int NPOINT      = 32;
  localparam int SAMPLE_W    = 64;
  localparam int FFT_LATENCY = 8;

  typedef struct {
    logic [31:0] re0;
    logic [31:0] re_step;
    logic [31:0] im0;
    logic [31:0] im_step;
    int          stall_mode;
    int          exp_drain;
    logic [15:0] exp_fc;
  } vec_t;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       fft_reset;
  logic [NPOINT*SAMPLE_W-1:0] fft_in;
  logic [NPOINT*SAMPLE_W-1:0] fft_out;
  logic                       busy;
  logic [15:0]                frame_count;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  fft_frame_sequencer_if #(.SAMPLE_W(SAMPLE_W)) io ();

  fft_frame_sequencer #(
    .NPOINT(NPOINT), .SAMPLE_W(SAMPLE_W), .FFT_LATENCY(FFT_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .io(io), .fft_reset(fft_reset), .fft_in(fft_in),
    .fft_out(fft_out), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: bin k is sample 31-k with real and imaginary halves swapped.
  always_comb begin
    fft_out = '0;
    for (int k = 0; k < NPOINT; k++)
      fft_out[k*SAMPLE_W +: SAMPLE_W] = {fft_in[(31-k)*SAMPLE_W +: 32], fft_in[(31-k)*SAMPLE_W+32 +: 32]};
  end

  function automatic logic [63:0] sample_of(vec_t v, int k);
    logic [31:0] r, i;
    r = v.re0 + v.re_step * 32'(k);
    i = v.im0 + v.im_step * 32'(k);
    return {r, i};
  endfunction

  function automatic logic [4:0] order(int i);
    logic [4:0] x;
    x = i[4:0];
`ifdef FFT_SEQ_BITREV_EN
    return {x[0], x[1], x[2], x[3], x[4]};
`else
    return x;
`endif
  endfunction

  function automatic logic [63:0] exp_bin(vec_t v, int i);
    logic [63:0] s;
    s = sample_of(v, 31 - int'(order(i)));
    return {s[31:0], s[63:32]};
  endfunction

  function automatic logic [NPOINT*SAMPLE_W-1:0] exp_frame(vec_t v);
    logic [NPOINT*SAMPLE_W-1:0] f;
    for (int k = 0; k < NPOINT; k++) f[k*SAMPLE_W +: SAMPLE_W] = sample_of(v, k);
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    repeat (n) step();
    checkOutput("rst_in_ready", 64'(io.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(io.out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(io.out_last), 64'd0);
    checkOutput("rst_out_data", io.out_data, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_fft_reset", 64'(fft_reset), 64'd1);
    checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
    checkOutput("rst_fft_in_zero", 64'(fft_in == '0), 64'd1);
    reset = 1'b0;
    step();
    checkOutput("release_in_ready", 64'(io.in_ready), 64'd1);
    checkOutput("release_fft_reset", 64'(fft_reset), 64'd0);
  endtask

  // Offers n samples back-to-back; h is the cycle whose handshake accepted the last one.
  task automatic loadFrame(input vec_t v, input int n, input bit no_out, output int h);
    int k, guard;
    logic acc;
    k = 0;
    guard = 0;
    h = -1;
    io.in_valid = 1'b1;
    io.in_data = sample_of(v, 0);
    while (k < n && guard < 400) begin
      acc = io.in_ready;
      if (busy) checkOutput("in_ready_while_busy", 64'(io.in_ready), 64'd0);
      if (no_out) checkOutput("no_early_out_valid", 64'(io.out_valid), 64'd0);
      if (acc && k == n - 1) h = cyc;
      step();
      guard++;
      if (acc) begin
        k++;
        io.in_data = sample_of(v, k);
      end
    end
    io.in_valid = 1'b0;
    if (k < n) checkOutput("load_timeout", 64'(k), 64'(n));
  endtask

  // Called in cycle h+1; runs until the first out_valid.
  task automatic waitResult(input vec_t v, input int h);
    int rst_cnt, rst_first, guard;
    bit stable;
    logic [NPOINT*SAMPLE_W-1:0] snap;
    rst_cnt = 0;
    rst_first = -1;
    guard = 0;
    stable = 1'b1;
    snap = fft_in;
    checkOutput("fft_in_frame", 64'(fft_in == exp_frame(v)), 64'd1);
    while (!io.out_valid && guard < 300) begin
      if (fft_reset) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = cyc;
      end
      if (fft_in !== snap) stable = 1'b0;
      step();
      guard++;
    end
    checkOutput("result_timeout", 64'(io.out_valid), 64'd1);
    checkOutput("fft_reset_pulse_len", 64'(rst_cnt), 64'd1);
    checkOutput("fft_reset_offset", 64'(rst_first - h), 64'd1);
    checkOutput("first_valid_latency", 64'(cyc - h), 64'(2 + FFT_LATENCY));
    checkOutput("fft_in_stable", 64'(stable), 64'd1);
  endtask

  task automatic drainFrame(input vec_t v, output int last_cyc);
    int i, guard, start;
    bit stalled;
    logic [63:0] held;
    logic [63:0] held_last;
    i = 0;
    guard = 0;
    start = cyc;
    stalled = 1'b0;
    held = '0;
    held_last = '0;
    last_cyc = -1;
    while (i < 32 && guard < 200) begin
      io.out_ready = (v.stall_mode == 0) ? 1'b1 : (guard % 2 == 0);
      checkOutput("out_valid_in_drain", 64'(io.out_valid), 64'd1);
      checkOutput("out_last_flag", 64'(io.out_last), 64'(i == 31));
      if (stalled) begin
        checkOutput("stall_hold_data", io.out_data, held);
        checkOutput("stall_hold_last", 64'(io.out_last), held_last);
      end
      if (io.out_valid && io.out_ready) begin
        checkOutput($sformatf("bin_%0d", i), io.out_data, exp_bin(v, i));
        if (i == 31) last_cyc = cyc;
        i++;
        stalled = 1'b0;
      end else begin
        held = io.out_data;
        held_last = 64'(io.out_last);
        stalled = 1'b1;
      end
      step();
      guard++;
    end
    io.out_ready = 1'b0;
    checkOutput("drain_cycles", 64'(cyc - start), 64'(v.exp_drain));
    checkOutput("frame_count", 64'(frame_count), 64'(v.exp_fc));
  endtask

  task automatic applyStimulus(input vec_t v);
    int h, lc;
    loadFrame(v, 32, 1'b1, h);
    waitResult(v, h);
    drainFrame(v, lc);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[3];
    vec_t vx, vr, va, vb;
    int h, ha, hb, last_a, last_b;

    vecs[0] = '{32'd0, 32'd1, 32'd0, 32'd0, 0, 32, 16'd1};
    vecs[1] = '{32'd31, 32'hFFFF_FFFF, 32'd31, 32'hFFFF_FFFF, 1, 63, 16'd2};
    vecs[2] = '{32'hDEAD_0000, 32'd3, 32'h1234_5678, 32'h0101_0101, 0, 32, 16'd3};
    vx = '{32'hBAD0_0000, 32'd1, 32'hBAD1_0000, 32'd1, 0, 32, 16'd0};
    vr = '{32'h0000_1000, 32'd7, 32'hFFFF_0000, 32'd5, 0, 32, 16'd1};
    va = '{32'hA000_0000, 32'd1, 32'h0000_00A0, 32'd2, 0, 32, 16'd1};
    vb = '{32'hB000_0000, 32'd9, 32'h0000_0B00, 32'd4, 1, 63, 16'd2};

    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    applyReset(3);

    for (int t = 0; t < 3; t++) applyStimulus(vecs[t]);

    // Abort a partially loaded frame; only the next full frame may come out.
    loadFrame(vx, 17, 1'b1, h);
    applyReset(2);
    applyStimulus(vr);

    // Frame B streams in during A's drain; its last sample lands with A's out_last handshake.
    applyReset(1);
    loadFrame(va, 32, 1'b1, ha);
    fork
      loadFrame(vb, 32, 1'b0, hb);
      begin
        waitResult(va, ha);
        drainFrame(va, last_a);
      end
    join
    checkOutput("overlap_same_cycle", 64'(hb), 64'(last_a));
    waitResult(vb, hb);
    drainFrame(vb, last_b);
    checkOutput("idle_after_drain", 64'(io.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
